// File: rtl/bin_bcd_pkg.sv
// Shared types, defaults and width helper for the binary/BCD converters.
package bin_bcd_pkg;

  localparam int unsigned DEC_W_DEF = 8;

  // Binary width able to hold any dec_w-digit decimal number.
  function automatic int unsigned bin_w(input int unsigned dec_w);
    return $unsigned($clog2(10 ** dec_w));
  endfunction

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    LOAD,
    WORK,
    DONE
  } state_t;

endpackage

// File: rtl/bin_bcd_codec_bcd2bin.sv
// Free-running packed-BCD to binary converter, MSD-first multiply-accumulate.
module bcd2bin
  import bin_bcd_pkg::*;
#(
  parameter int unsigned DEC_W = DEC_W_DEF,
  parameter int unsigned BIN_W = bin_w(DEC_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  digit_t [DEC_W-1:0] in,
  output logic [BIN_W-1:0]   out,
  output logic               rdy
);

  localparam int unsigned CNT_W = $clog2(DEC_W + 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  digit_t [DEC_W-1:0] sh;
  logic [BIN_W-1:0]   acc;
  logic               last;
  logic               load;
  logic               step;
  logic               done;

  assign last = (cnt == CNT_W'(DEC_W - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next state: LOAD -> WORK (DEC_W cycles) -> DONE -> LOAD.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    state_nxt = WORK;
      WORK:    if (last) state_nxt = DONE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    done = 1'b0;
    unique case (state)
      LOAD:    load = 1'b1;
      WORK:    step = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Digit shift register, x10 accumulator, cycle counter and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
      out <= '0;
      rdy <= 1'b0;
    end else begin
      rdy <= done;
      if (load) begin
        sh  <= in;
        acc <= '0;
        cnt <= '0;
      end
      if (step) begin
        // Digits above 9 are weighted as-is; arithmetic wraps at 2^BIN_W.
        acc <= (acc << 3) + (acc << 1) + BIN_W'(sh[DEC_W-1]);
        sh  <= sh << 4;
        cnt <= cnt + CNT_W'(1);
      end
      if (done) out <= acc;
    end
  end

endmodule

// File: rtl/bin_bcd_codec_bin2bcd.sv
// Free-running double-dabble binary to packed-BCD converter.
module bin2bcd
  import bin_bcd_pkg::*;
#(
  parameter int unsigned DEC_W = DEC_W_DEF,
  parameter int unsigned BIN_W = bin_w(DEC_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BIN_W-1:0]   in,
  output digit_t [DEC_W-1:0] out,
  output logic               rdy
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned ACC_W = 4 * DEC_W;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   sh;
  digit_t [DEC_W-1:0] acc;
  digit_t [DEC_W-1:0] acc_adj;
  logic [ACC_W-1:0]   adj_flat;
  logic               last;
  logic               load;
  logic               step;
  logic               done;

  assign last = (cnt == CNT_W'(BIN_W - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next state: LOAD -> WORK (BIN_W cycles) -> DONE -> LOAD.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    state_nxt = WORK;
      WORK:    if (last) state_nxt = DONE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    done = 1'b0;
    unique case (state)
      LOAD:    load = 1'b1;
      WORK:    step = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Add-3 correction on every digit that would overflow when doubled.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < int'(DEC_W); i++) begin
      acc_adj[i] = (acc[i] >= 4'd5) ? acc[i] + 4'd3 : acc[i];
    end
    adj_flat = acc_adj;
  end

  // Shift register, accumulator, cycle counter and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
      out <= '0;
      rdy <= 1'b0;
    end else begin
      rdy <= done;
      if (load) begin
        sh  <= in;
        acc <= '0;
        cnt <= '0;
      end
      if (step) begin
        // Carry out of the top digit is dropped: result is modulo 10^DEC_W.
        acc <= ACC_W'({adj_flat, sh[BIN_W-1]});
        sh  <= sh << 1;
        cnt <= cnt + CNT_W'(1);
      end
      if (done) out <= acc;
    end
  end

endmodule

// File: rtl/bin_bcd_codec.sv
// Independent binary->BCD and BCD->binary converters sharing one clock.
module bin_bcd_codec
  import bin_bcd_pkg::*;
#(
  parameter int unsigned DEC_W = DEC_W_DEF,
  parameter int unsigned BIN_W = bin_w(DEC_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BIN_W-1:0]   bin_in,
  output digit_t [DEC_W-1:0] bcd_out,
  output logic               bin2bcd_rdy,
  input  digit_t [DEC_W-1:0] bcd_in,
  output logic [BIN_W-1:0]   bin_out,
  output logic               bcd2bin_rdy
);

  bin2bcd #(
    .DEC_W(DEC_W),
    .BIN_W(BIN_W)
  ) u_bin2bcd (
    .clk(clk),
    .rst(rst),
    .in (bin_in),
    .out(bcd_out),
    .rdy(bin2bcd_rdy)
  );

  bcd2bin #(
    .DEC_W(DEC_W),
    .BIN_W(BIN_W)
  ) u_bcd2bin (
    .clk(clk),
    .rst(rst),
    .in (bcd_in),
    .out(bin_out),
    .rdy(bcd2bin_rdy)
  );

endmodule

// File: tb/tb_bin_bcd_codec.sv
// Directed self-checking bench for bin_bcd_codec at default widths.
module tb_bin_bcd_codec;

  localparam int unsigned DEC_W = 8;
  localparam int unsigned BIN_W = 27;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [BIN_W-1:0]       bin_in = '0;
  logic [DEC_W-1:0][3:0]  bcd_out;
  logic                   bin2bcd_rdy;
  logic [DEC_W-1:0][3:0]  bcd_drv = '0;
  logic [DEC_W-1:0][3:0]  bcd_in;
  logic [BIN_W-1:0]       bin_out;
  logic                   bcd2bin_rdy;
  logic                   lb = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  assign bcd_in = lb ? bcd_out : bcd_drv;

  bin_bcd_codec #(
    .DEC_W(DEC_W),
    .BIN_W(BIN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bin_in     (bin_in),
    .bcd_out    (bcd_out),
    .bin2bcd_rdy(bin2bcd_rdy),
    .bcd_in     (bcd_in),
    .bin_out    (bin_out),
    .bcd2bin_rdy(bcd2bin_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next strobe of one converter; sel=1 selects bcd2bin.
  task automatic wait_rdy(input bit sel, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk); #1;
      seen = sel ? bcd2bin_rdy : bin2bcd_rdy;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic run_b2d(input logic [BIN_W-1:0] v, input logic [31:0] exp, input string tag);
    bin_in = v;
    wait_rdy(1'b0, {tag, "_w1"});
    wait_rdy(1'b0, {tag, "_w2"});
    check(tag, 64'(bcd_out), 64'(exp));
  endtask

  task automatic run_d2b(input logic [31:0] v, input logic [BIN_W-1:0] exp, input string tag);
    bcd_drv = v;
    wait_rdy(1'b1, {tag, "_w1"});
    wait_rdy(1'b1, {tag, "_w2"});
    check(tag, 64'(bin_out), 64'(exp));
  endtask

  // Strobe spacing and one-cycle pulse width.
  task automatic measure(input bit sel, input int exp_p, input string tag);
    int n = 0;
    bit seen = 1'b0;
    wait_rdy(sel, {tag, "_sync"});
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      seen = sel ? bcd2bin_rdy : bin2bcd_rdy;
      if (n == 1) check({tag, "_width"}, 64'(seen), 64'd0);
    end
    check(tag, 64'(n), 64'(exp_p));
  endtask

  // Release reset and record the edge number of each converter's first strobe.
  task automatic release_and_time(input logic [31:0] exp_bcd, input logic [BIN_W-1:0] exp_bin,
                                  input string tag);
    int first_b2d = 0;
    int first_d2b = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (bcd2bin_rdy && first_d2b == 0) begin
        first_d2b = e;
        check({tag, "_bin_out"}, 64'(bin_out), 64'(exp_bin));
      end
      if (bin2bcd_rdy && first_b2d == 0) begin
        first_b2d = e;
        check({tag, "_bcd_out"}, 64'(bcd_out), 64'(exp_bcd));
      end
    end
    check({tag, "_first_d2b_edge"}, 64'(first_d2b), 64'd10);
    check({tag, "_first_b2d_edge"}, 64'(first_b2d), 64'd29);
  endtask

  initial begin
    bin_in  = 27'd12345678;
    bcd_drv = 32'h12345678;

    // Reset held: everything quiet.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("reset_outs", {bcd_out, bin2bcd_rdy, bcd2bin_rdy}, 64'd0);
      check("reset_bin_out", 64'(bin_out), 64'd0);
    end

    release_and_time(32'h12345678, 27'd12345678, "first");

    // Directed conversions.
    run_b2d(27'd99999999,  32'h99999999, "b2d_all9");
    run_b2d(27'd100000000, 32'h00000000, "b2d_1e8_wrap");
    run_b2d(27'd134217727, 32'h34217727, "b2d_max");
    run_b2d(27'd0,         32'h00000000, "b2d_zero");
    run_d2b(32'h99999999,  27'd99999999, "d2b_all9");
    run_d2b(32'h000000A0,  27'd100,      "d2b_digit_gt9");
    run_d2b(32'h00000001,  27'd1,        "d2b_one");

    // Input change during WORK is ignored until the next LOAD.
    bin_in = 27'd5;
    wait_rdy(1'b0, "midwork_sync");
    repeat (10) @(posedge clk);
    #1 bin_in = 27'd7;
    wait_rdy(1'b0, "midwork_w1");
    check("midwork_cur", 64'(bcd_out), 64'h5);
    wait_rdy(1'b0, "midwork_w2");
    check("midwork_next", 64'(bcd_out), 64'h7);

    measure(1'b0, 29, "b2d_period");
    measure(1'b1, 10, "d2b_period");

    // Asynchronous reset in the middle of a conversion.
    bin_in  = 27'd4321;
    bcd_drv = 32'h00000042;
    wait_rdy(1'b0, "arst_sync1");
    wait_rdy(1'b0, "arst_sync2");
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_bcd_out", 64'(bcd_out), 64'd0);
    check("arst_bin_out", 64'(bin_out), 64'd0);
    check("arst_rdy", {bin2bcd_rdy, bcd2bin_rdy}, 64'd0);
    repeat (3) @(posedge clk);
    release_and_time(32'h00004321, 27'd42, "restart");

    // Loopback: bin_in -> bcd_out -> bcd_in -> bin_out.
    lb = 1'b1;
    for (int i = 0; i < 50; i++) begin
      int v;
      v = (i < 30) ? i : i * 1999999 + 7;
      @(posedge clk); #1;
      bin_in = BIN_W'(v);
      repeat (78) @(posedge clk);
      #1 check("loopback", 64'(bin_out), 64'(v));
      repeat (20) @(posedge clk);
    end
    lb = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
